// File: rtl/wb_trace_pkg.sv
// wb_trace_pkg - shared constants, types and helpers for the writeback trace
// transmitter.
//
// Build option: define TRACE_PC_EN to append the committing PC to every
// frame (10-byte frames, 69-bit FIFO entries). Without it frames are 6 bytes
// and FIFO entries are 37 bits.
//
// FIFO entry layout (LSB first): rd[4:0], data[36:5], pc[68:37] (PC only
// when TRACE_PC_EN is defined).
package wb_trace_pkg;

  localparam logic [7:0] TRACE_HDR = 8'hA5;

`ifdef TRACE_PC_EN
  localparam int FRAME_LEN = 10;
  localparam int ENTRY_W   = 69;
`else
  localparam int FRAME_LEN = 6;
  localparam int ENTRY_W   = 37;
`endif

  localparam int IDX_W = $clog2(FRAME_LEN);

  typedef enum logic {IDLE, SEND} ser_state_t;

  // Byte i of the on-wire frame built from one FIFO entry.
  function automatic logic [7:0] frame_byte(input logic [ENTRY_W-1:0] e,
                                            input logic [IDX_W-1:0]   i);
    logic [7:0] b;
    case (int'(i))
      0:       b = TRACE_HDR;
      1:       b = {3'b000, e[4:0]};
      2:       b = e[12:5];
      3:       b = e[20:13];
      4:       b = e[28:21];
      5:       b = e[36:29];
`ifdef TRACE_PC_EN
      6:       b = e[44:37];
      7:       b = e[52:45];
      8:       b = e[60:53];
      9:       b = e[68:61];
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo - synchronous FIFO used to buffer writeback events.
//
// Ports:
//   clk, rst   clock; synchronous active-low reset
//   push, din  write request and data (ignored when full unless popping)
//   pop, dout  read request (ignored when empty); dout shows the head entry
//   full       DEPTH entries stored
//   empty      no entries stored
//   level      number of stored entries
//
// Push and pop on the same edge while full both succeed and keep the level.
// DEPTH must be a power of two so the pointers wrap naturally.
module trace_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign dout    = mem[rd_ptr];
  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_trace_tx.sv
// wb_trace_tx - register-writeback trace transmitter.
//
// Watches CPU commits, buffers each register write (rd != 0) in a FIFO and
// serializes it as a little-endian byte frame on a valid/ready stream:
//   A5, {3'b0, rd}, data[7:0], data[15:8], data[23:16], data[31:24]
//   (+ pc bytes 0..3 when built with TRACE_PC_EN defined)
//
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   wb_valid, wb_rd      commit strobe and destination register
//   wb_data, wb_pc       written value and PC (PC used only with TRACE_PC_EN)
//   tx_data, tx_valid    frame byte stream (held stable while not accepted)
//   tx_ready             sink accepts the current byte
//   fifo_level           entries waiting in the FIFO (excludes current frame)
//   overflow, drop_cnt   sticky drop flag and saturating drop count
//   ovf_clr              clears overflow and drop_cnt (a same-edge drop wins)
module wb_trace_tx
  import wb_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_rd,
  input  logic [31:0]              wb_data,
  input  logic [31:0]              wb_pc,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [CNT_W-1:0]         drop_cnt
);

  ser_state_t         state;
  logic [ENTRY_W-1:0] frame;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   next_idx;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               is_event;
  logic               drop;
  logic               last_byte;

  // Writes to x0 are architecturally meaningless and are not traced.
  assign is_event = wb_valid && (wb_rd != 5'd0);

`ifdef TRACE_PC_EN
  assign fifo_din = {wb_pc, wb_data, wb_rd};
`else
  logic unused_pc;
  assign unused_pc = ^wb_pc;
  assign fifo_din  = {wb_data, wb_rd};
`endif

  assign last_byte = (idx == IDX_W'(FRAME_LEN - 1));
  assign next_idx  = idx + 1'b1;

  // Pop whenever the serializer can take a new frame: from IDLE, or on
  // acceptance of the last byte so consecutive frames run without a bubble.
  always_comb begin
    fifo_pop = 1'b0;
    if (state == IDLE) begin
      fifo_pop = !fifo_empty;
    end else begin
      fifo_pop = tx_ready && last_byte && !fifo_empty;
    end
  end

  assign drop = is_event && fifo_full && !fifo_pop;

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (is_event),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Drop bookkeeping; a drop on the same edge as ovf_clr restarts the count at 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_clr) begin
        drop_cnt <= CNT_W'(1);
      end else if (!(&drop_cnt)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  // Serializer: tx_data is registered and always precomputed for the byte
  // that will be on the wire next, so it holds steady under backpressure.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      frame    <= '0;
      idx      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            frame    <= fifo_dout;
            idx      <= '0;
            state    <= SEND;
            tx_valid <= 1'b1;
            tx_data  <= TRACE_HDR;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (last_byte) begin
              if (!fifo_empty) begin
                frame   <= fifo_dout;
                idx     <= '0;
                tx_data <= TRACE_HDR;
              end else begin
                state    <= IDLE;
                idx      <= '0;
                tx_valid <= 1'b0;
                tx_data  <= 8'h00;
              end
            end else begin
              idx     <= next_idx;
              tx_data <= frame_byte(frame, next_idx);
            end
          end
        end
        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_trace_tx.sv
// tb_wb_trace_tx - scoreboard bench for wb_trace_tx.
//
// Stimulus pushes the hand-built expected frame bytes into a queue; a monitor
// on the falling edge pops and compares every byte the DUT hands over
// (tx_valid && tx_ready). Directed checks cover reset, latency, backpressure,
// overflow, full push+pop and reset mid-frame.
module tb_wb_trace_tx;
  import wb_trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [$clog2(DEPTH):0] fifo_level;
  logic        overflow;
  logic        ovf_clr;
  logic [CNT_W-1:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;

  wb_trace_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_pc      (wb_pc),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle commit; when expect_frame is set the frame is queued for the monitor.
  task automatic applyStimulus(input logic [4:0] rd, input logic [31:0] data,
                               input logic [31:0] pc, input bit expect_frame);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = data;
    wb_pc    = pc;
    if (expect_frame) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back({3'b000, rd});
      exp_q.push_back(data[7:0]);
      exp_q.push_back(data[15:8]);
      exp_q.push_back(data[23:16]);
      exp_q.push_back(data[31:24]);
`ifdef TRACE_PC_EN
      exp_q.push_back(pc[7:0]);
      exp_q.push_back(pc[15:8]);
      exp_q.push_back(pc[23:16]);
      exp_q.push_back(pc[31:24]);
`endif
    end
    tick();
    wb_valid = 1'b0;
    wb_rd    = 5'd0;
  endtask

  // Wait (bounded) until every queued byte has been delivered, then expect IDLE.
  task automatic drain(input bit check_gaps, input string name);
    int gaps;
    int cyc;
    gaps = 0;
    cyc  = 0;
    while (exp_q.size() != 0 && cyc < 500) begin
      if (tx_valid !== 1'b1) gaps++;
      tick();
      cyc++;
    end
    checkOutput({name, "_pending"}, exp_q.size(), 0);
    if (check_gaps) checkOutput({name, "_gaps"}, gaps, 0);
    tick();
    checkOutput({name, "_idle"}, {31'd0, tx_valid}, 0);
  endtask

  // Scoreboard monitor: every handshake consumes one expected byte.
  always @(negedge clk) begin
    if (rst === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte", tx_data);
      end else begin
        exp_byte = exp_q.pop_front();
        checkOutput("tx_byte", {24'd0, tx_data}, {24'd0, exp_byte});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b0;
    wb_valid = 1'b0;
    wb_rd    = 5'd0;
    wb_data  = 32'd0;
    wb_pc    = 32'd0;
    tx_ready = 1'b1;
    ovf_clr  = 1'b0;
    repeat (3) tick();
    rst = 1'b1;

    // Reset state
    checkOutput("rst_tx_valid", {31'd0, tx_valid}, 0);
    checkOutput("rst_tx_data", {24'd0, tx_data}, 0);
    checkOutput("rst_fifo_level", {28'd0, fifo_level}, 0);
    checkOutput("rst_overflow", {31'd0, overflow}, 0);
    checkOutput("rst_drop_cnt", {16'd0, drop_cnt}, 0);

    // Single event: latency of two cycles, then the whole frame
    $display("[TB] single event");
    applyStimulus(5'd5, 32'h12345678, 32'h00000100, 1'b1);
    checkOutput("lat_level", {28'd0, fifo_level}, 1);
    checkOutput("lat_valid_e1", {31'd0, tx_valid}, 0);
    tick();
    checkOutput("lat_valid_e2", {31'd0, tx_valid}, 1);
    checkOutput("lat_hdr", {24'd0, tx_data}, 32'hA5);
    drain(1'b1, "single");

    // x0 write is ignored and never counted as a drop
    $display("[TB] rd zero");
    applyStimulus(5'd0, 32'hDEADBEEF, 32'h0, 1'b0);
    checkOutput("rd0_level", {28'd0, fifo_level}, 0);
    tick();
    tick();
    checkOutput("rd0_valid", {31'd0, tx_valid}, 0);
    checkOutput("rd0_drop_cnt", {16'd0, drop_cnt}, 0);
    checkOutput("rd0_overflow", {31'd0, overflow}, 0);

    // Backpressure at byte2
    $display("[TB] backpressure");
    applyStimulus(5'd5, 32'h12345678, 32'h0, 1'b1);
    tick();
    tick();
    tick();
    tx_ready = 1'b0;
    checkOutput("bp_byte2", {24'd0, tx_data}, 32'h78);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_hold_valid", {31'd0, tx_valid}, 1);
      checkOutput("bp_hold_data", {24'd0, tx_data}, 32'h78);
    end
    tx_ready = 1'b1;
    drain(1'b1, "bp");

    // Overflow: rd=1 goes to the serializer, 2..9 fill the FIFO, 10..12 drop
    $display("[TB] overflow");
    tx_ready = 1'b0;
    for (int r = 1; r <= 12; r++) begin
      applyStimulus(5'(r), 32'hA0B0C000 + 32'(r), 32'h0, (r <= 9));
    end
    checkOutput("ovf_level", {28'd0, fifo_level}, 8);
    checkOutput("ovf_drop_cnt", {16'd0, drop_cnt}, 3);
    checkOutput("ovf_flag", {31'd0, overflow}, 1);

    // Release; new event lands on the edge the last byte of rd=1 is accepted
    tx_ready = 1'b1;
    repeat (FRAME_LEN - 1) tick();
    applyStimulus(5'd13, 32'h0D0D0D0D, 32'h0, 1'b1);
    checkOutput("full_pp_level", {28'd0, fifo_level}, 8);
    checkOutput("full_pp_drop_cnt", {16'd0, drop_cnt}, 3);
    drain(1'b1, "ovf_drain");

    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checkOutput("clr_overflow", {31'd0, overflow}, 0);
    checkOutput("clr_drop_cnt", {16'd0, drop_cnt}, 0);

    // Reset during byte3 abandons the frame and the queued entry
    $display("[TB] reset mid-frame");
    applyStimulus(5'd7, 32'hCAFEF00D, 32'h0, 1'b1);
    applyStimulus(5'd8, 32'h11223344, 32'h0, 1'b1);
    tick();
    tick();
    tick();
    checkOutput("mid_byte3", {24'd0, tx_data}, 32'hF0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_q.delete();
    checkOutput("mid_rst_valid", {31'd0, tx_valid}, 0);
    checkOutput("mid_rst_level", {28'd0, fifo_level}, 0);
    tick();
    checkOutput("mid_rst_idle", {31'd0, tx_valid}, 0);
    applyStimulus(5'd9, 32'h01020304, 32'h00000100, 1'b1);
    tick();
    checkOutput("post_rst_hdr", {24'd0, tx_data}, 32'hA5);
    drain(1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_trace_tx.md
Name: wb_trace_tx

Overview:
- Hardware transmitter for register-writeback trace records.
- Sits beside the CPU writeback stage and watches each commit (reg_write, rd, write_data).
- Buffers committed events in a small FIFO and serializes each one as a fixed byte frame on a valid/ready byte stream, so a host or UART bridge can reconstruct the register-write history.

Parameters:
- DEPTH, 8, FIFO entries (power of 2, >=2).
- CNT_W, 16, width of dropped-event counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-low.
- wb_valid  in  1  writeback commit this cycle (CPU reg_write).
- wb_rd  in  5  destination register.
- wb_data  in  32  value written.
- wb_pc  in  32  PC of committing instruction (used only with TRACE_PC_EN).
- tx_data  out  8  frame byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte.
- fifo_level  out  $clog2(DEPTH)+1  queued entries.
- overflow  out  1  sticky: an event was dropped.
- ovf_clr  in  1  clears overflow and drop_cnt.
- drop_cnt  out  CNT_W  dropped events, saturating.

Behaviour:
- Reset (rst==0 at posedge):
  - All outputs go to 0: tx_valid=0, tx_data=0, fifo_level=0, overflow=0, drop_cnt=0.
  - FIFO pointers cleared and serializer set to IDLE.
  - Reset mid-frame abandons the frame; no partial frame resumes after reset.
- Capture:
  - wb_valid=1 with wb_rd!=0 is an event. wb_rd==0 is ignored and never counted as a drop.
  - An event is pushed at the sampling edge if the FIFO is not full, or if it is full and a pop occurs on the same edge (push and pop both succeed; level unchanged).
  - Otherwise the event is dropped: overflow<=1 and drop_cnt increments, saturating at all-ones.
  - If ovf_clr and a drop occur on the same edge, the drop wins: overflow=1, drop_cnt=1.
- Frame format (little-endian), FRAME_LEN=6:
  - byte0 = 8'hA5 header.
  - byte1 = {3'b000, rd}.
  - bytes2..5 = data[7:0], data[15:8], data[23:16], data[31:24].
- Serializer FSM:
  - IDLE:
    - tx_valid=0.
    - If the FIFO is non-empty: pop the head into the frame register, idx<=0, go to SEND.
  - SEND:
    - tx_valid=1, tx_data=frame byte[idx].
    - On tx_valid&&tx_ready: idx<=idx+1.
    - On acceptance of the last byte: if the FIFO is non-empty, pop and load the next frame in the same edge (no bubble, stay SEND, idx<=0); else go to IDLE.
  - tx_data and tx_valid stay stable while tx_valid&&!tx_ready (AXI-style hold).
- Latency:
  - Event sampled at edge E into an empty FIFO with the serializer IDLE: pop/load at E+1; tx_valid high for the cycle after E+1.
  - Frame throughput is FRAME_LEN cycles with tx_ready held at 1.
- Capacity:
  - Capacity is DEPTH FIFO entries plus 1 frame held in the serializer.
  - fifo_level counts FIFO entries only.

Optional Feature:
- Macro: TRACE_PC_EN.
- Defined: FRAME_LEN=10. Frame appends wb_pc bytes 6..9, little-endian. FIFO entry width = 69 bits (rd + data + pc).
- Undefined: FRAME_LEN=6. wb_pc is unused. FIFO entry width = 37 bits.

Decomposition:
- Package wb_trace_pkg holds:
  - TRACE_HDR=8'hA5.
  - FRAME_LEN (conditional on TRACE_PC_EN).
  - Entry width constant.
  - Serializer state enum {IDLE, SEND}.
- Sub-module trace_fifo: synchronous FIFO.
  - Parameters WIDTH and DEPTH.
  - Ports push, pop, din, dout, full, empty, level.
  - Simultaneous push+pop when full is legal.
- wb_trace_tx holds capture logic, drop counter and serializer FSM.

Test Plan:
- Single event: wb_rd=5, wb_data=0x12345678, tx_ready=1 → tx_valid rises 2 cycles after the event; bytes A5 05 78 56 34 12 on consecutive cycles; back to IDLE.
- wb_rd=0 with wb_valid=1 and data 0xDEADBEEF → no frame; fifo_level=0; drop_cnt=0.
- Backpressure: hold tx_ready=0 for 5 cycles mid-frame, at byte2 → tx_data stays 0x78 and tx_valid stays 1; the sequence completes correctly after release.
- Overflow: tx_ready=0, 12 consecutive events (rd=1..12) with DEPTH=8 → fifo_level=8, drop_cnt=3, overflow=1. After release, frames for rd=1..9 are emitted in order, back-to-back with no idle cycle. ovf_clr then gives overflow=0, drop_cnt=0.
- Full with simultaneous push/pop: FIFO full and last byte accepted on the same edge as a new event → event accepted; fifo_level stays 8; drop_cnt unchanged.
- Reset mid-frame: rst=0 during byte3 → next cycle tx_valid=0 and fifo_level=0. A new event after reset produces a clean frame starting with A5.
- With TRACE_PC_EN: wb_pc=0x00000100 → frame has 10 bytes, ending 00 01 00 00.
